mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Multi-cycle MIPS main control unit that sequences the shared datapath (single memory, single ALU, register file, PC/IR) one instruction at a time. It decodes the 6-bit opcode and produces per-state datapath strobes, including the 2-bit alu_Op that feeds the ALU control decoder. Memory accesses use a ready handshake with a wait-state timeout, and a sticky error state is entered on illegal opcode or memory timeout.

Parameters:
MAX_WAIT, 15, consecutive not-ready cycles allowed in a memory state before timeout; 0 disables the timeout.
STATE_W, 4, state register width.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26], sampled in DECODE
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
mem_to_reg  output  1  register write-data select: 1 = MDR
ir_write  output  1  IR load
reg_dst  output  1  destination register select: 1 = rd, 0 = rt
reg_write  output  1  register file write
alu_src_a  output  1  ALU A select: 0 = PC, 1 = A register
alu_src_b  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate
alu_Op  output  2  00 = add, 01 = sub, 10 = use funct
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
state  output  STATE_W  current state, for debug
err_code  output  2  sticky: 00 none, 01 illegal opcode, 10 memory timeout

Behaviour:
- Reset (async, rst_n=0): state=FETCH, err_code=00, wait counter=0. All strobes are forced to 0 while rst_n=0; the first fetch begins on the first clock edge after release.
- All outputs decode combinationally from state. Exception: in FETCH, ir_write and pc_write equal mem_ready (Mealy). Any strobe not listed for a state is 0.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_Op=00, pc_source=00. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE(1): alu_src_b=11, alu_Op=00. Next state by opcode:
  - lw or sw -> MEM_ADDR
  - R -> EXECUTE
  - beq -> BRANCH
  - j -> JUMP
  - addi -> ADDI_EXEC
  - any other opcode -> ERROR, err_code=01
- MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_Op=00. Next is MEM_READ for lw, MEM_WRITE for sw, using the opcode held stable in the IR.
- MEM_READ(3): mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Next is FETCH.
- MEM_WRITE(5): mem_write=1, i_or_d=1. Waits for mem_ready, then goes to FETCH.
- EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_Op=10. Next is R_COMPLETE(7).
- R_COMPLETE(7): reg_dst=1, reg_write=1. Next is FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, alu_Op=01, pc_write_cond=1, pc_source=01. Next is FETCH.
- JUMP(9): pc_write=1, pc_source=10. Next is FETCH.
- ADDI_EXEC(10): alu_src_a=1, alu_src_b=10, alu_Op=00. Next is ADDI_WB(11).
- ADDI_WB(11): reg_dst=0, reg_write=1. Next is FETCH.
- ERROR(15): all strobes 0. Absorbing; only rst_n exits. err_code holds.
- Unused encodings (12-14) go to ERROR with err_code=01.
- Latencies with mem_ready held at 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R and addi: 4 cycles
  - beq and j: 3 cycles
  - each not-ready cycle adds 1.
- Timeout (memory states FETCH, MEM_READ, MEM_WRITE):
  - The wait counter clears on entry to a memory state and increments each cycle mem_ready=0.
  - If mem_ready=0 on the MAX_WAIT-th consecutive wait cycle, next state is ERROR with err_code=10.
  - mem_ready=1 on that same cycle wins and the FSM proceeds normally.
- Reset asserted mid-instruction aborts the instruction immediately; no strobe is issued after rst_n falls.

Optional Feature:
MC_INSTR_COUNT_EN:
- When defined, adds output instr_retired[31:0].
- Reset value 0. Increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_COMPLETE, BRANCH, JUMP or ADDI_WB. Wraps modulo 2^32.
- Never increments in ERROR.
- When not defined, the port and counter are absent.

Decomposition:
- Shared include file mips_ctrl_defs.vh holds:
  - state encodings
  - opcode constants
  - alu_Op encodings (ADD/SUB/FUNCT)
  - alu_src_b and pc_source encodings
  - err_code values
- Sub-module mem_wait_timer (inputs: clk, rst_n, start, ready; output: timeout; parameter MAX_WAIT) holds the wait counter.

Test Plan:
- lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4,0; mem_to_reg=1 and reg_write=1 in state 4 only; 5 cycles.
- sw with mem_ready low for 3 cycles in MEM_WRITE -> state 5 held 4 cycles, mem_write=1 throughout; total 7 cycles; reg_write never 1.
- R-type then beq -> alu_Op=10 in EXECUTE, alu_Op=01 with pc_write_cond=1 in BRANCH; j -> pc_write=1, pc_source=10 in state 9.
- opcode 111111 in DECODE -> state 15, err_code=01, all strobes 0 for 20+ cycles until rst_n pulse, then state 0.
- MAX_WAIT=15, mem_ready stuck at 0 in FETCH -> ERROR after the 15th wait cycle, err_code=10; variant with mem_ready=1 on the 15th cycle -> DECODE.
- rst_n dropped asynchronously mid-MEM_READ (between clock edges) -> strobes go to 0 immediately, state=0, err_code=00; with MC_INSTR_COUNT_EN, counter is 0 and reads 3 after lw, sw, j complete.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: state encodings, opcodes,
// ALU/mux select encodings and error codes.
package mc_control_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_MEM_ADDR   = 4'd2,
    S_MEM_READ   = 4'd3,
    S_MEM_WB     = 4'd4,
    S_MEM_WRITE  = 4'd5,
    S_EXECUTE    = 4'd6,
    S_R_COMPLETE = 4'd7,
    S_BRANCH     = 4'd8,
    S_JUMP       = 4'd9,
    S_ADDI_EXEC  = 4'd10,
    S_ADDI_WB    = 4'd11,
    S_ERROR      = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_control_fsm_mem_wait_timer.sv
// Consecutive not-ready cycle counter for memory states; flags the cycle on which
// the MAX_WAIT-th wait happens. MAX_WAIT = 0 disables the timeout.
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ready,
  output logic timeout
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'((MAX_WAIT > 0) ? (MAX_WAIT - 1) : 0);

  logic [CNT_W-1:0] cnt_r;

  // Wait counter: cleared on state entry or completion, saturates at the timeout point
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (start || ready) begin
      cnt_r <= '0;
    end else if (cnt_r != LAST_C) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign timeout = (MAX_WAIT != 0) && !ready && (cnt_r == LAST_C);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control FSM. Optional MC_INSTR_COUNT_EN adds a retired
// instruction counter output (instr_retired).
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int STATE_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_Op,
  output logic [1:0]         pc_source,
  output logic [STATE_W-1:0] state,
  output logic [1:0]         err_code
`ifdef MC_INSTR_COUNT_EN
  ,
  output logic [31:0]        instr_retired
`endif
);

  state_t     state_r, state_next_s;
  logic [1:0] err_r, err_next_s;
  logic       timeout_s, start_s;
  logic       pc_write_s, pc_write_cond_s, i_or_d_s, mem_read_s, mem_write_s;
  logic       mem_to_reg_s, ir_write_s, reg_dst_s, reg_write_s, alu_src_a_s;
  logic [1:0] alu_src_b_s, alu_op_s, pc_source_s;

  // Every entry into a memory state comes from a different state, so a state change restarts the count
  assign start_s = (state_next_s != state_r);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s),
    .ready   (mem_ready),
    .timeout (timeout_s)
  );

  // State and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
      err_r   <= ERR_NONE;
    end else begin
      state_r <= state_next_s;
      err_r   <= err_next_s;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_next_s    = state_r;
    err_next_s      = err_r;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    i_or_d_s        = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    mem_to_reg_s    = 1'b0;
    ir_write_s      = 1'b0;
    reg_dst_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    alu_src_b_s     = ALUB_REG;
    alu_op_s        = ALU_OP_ADD;
    pc_source_s     = PCSRC_ALU;
    case (state_r)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = ALUB_FOUR;
        ir_write_s  = mem_ready;
        pc_write_s  = mem_ready;
        if (mem_ready) begin
          state_next_s = S_DECODE;
        end else if (timeout_s) begin
          state_next_s = S_ERROR;
          err_next_s   = ERR_TIMEOUT;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b_s = ALUB_IMM_SH;
        case (opcode)
          OP_LW, OP_SW: state_next_s = S_MEM_ADDR;
          OP_R:         state_next_s = S_EXECUTE;
          OP_BEQ:       state_next_s = S_BRANCH;
          OP_J:         state_next_s = S_JUMP;
          OP_ADDI:      state_next_s = S_ADDI_EXEC;
          default: begin
            state_next_s = S_ERROR;
            err_next_s   = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = ALUB_IMM;
        if (opcode == OP_SW) begin
          state_next_s = S_MEM_WRITE;
        end else begin
          state_next_s = S_MEM_READ;
        end
      end
      S_MEM_READ, S_MEM_WRITE: begin
        i_or_d_s    = 1'b1;
        mem_read_s  = (state_r == S_MEM_READ);
        mem_write_s = (state_r == S_MEM_WRITE);
        if (mem_ready) begin
          state_next_s = (state_r == S_MEM_READ) ? S_MEM_WB : S_FETCH;
        end else if (timeout_s) begin
          state_next_s = S_ERROR;
          err_next_s   = ERR_TIMEOUT;
        end else begin
          state_next_s = state_r;
        end
      end
      S_MEM_WB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        state_next_s = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a_s  = 1'b1;
        alu_op_s     = ALU_OP_FUNCT;
        state_next_s = S_R_COMPLETE;
      end
      S_R_COMPLETE: begin
        reg_dst_s    = 1'b1;
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = ALU_OP_SUB;
        pc_write_cond_s = 1'b1;
        pc_source_s     = PCSRC_ALUOUT;
        state_next_s    = S_FETCH;
      end
      S_JUMP: begin
        pc_write_s   = 1'b1;
        pc_source_s  = PCSRC_JUMP;
        state_next_s = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = ALUB_IMM;
        state_next_s = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write_s  = 1'b1;
        state_next_s = S_FETCH;
      end
      S_ERROR: begin
        state_next_s = S_ERROR;
      end
      default: begin
        state_next_s = S_ERROR;
        err_next_s   = ERR_ILLEGAL;
      end
    endcase
  end

  // Reset gates the strobes so nothing (not even the Mealy FETCH terms) fires while rst_n is low
  assign pc_write      = pc_write_s & rst_n;
  assign pc_write_cond = pc_write_cond_s & rst_n;
  assign i_or_d        = i_or_d_s & rst_n;
  assign mem_read      = mem_read_s & rst_n;
  assign mem_write     = mem_write_s & rst_n;
  assign mem_to_reg    = mem_to_reg_s & rst_n;
  assign ir_write      = ir_write_s & rst_n;
  assign reg_dst       = reg_dst_s & rst_n;
  assign reg_write     = reg_write_s & rst_n;
  assign alu_src_a     = alu_src_a_s & rst_n;
  assign alu_src_b     = alu_src_b_s & {2{rst_n}};
  assign alu_Op        = alu_op_s & {2{rst_n}};
  assign pc_source     = pc_source_s & {2{rst_n}};
  assign state         = STATE_W'(state_r);
  assign err_code      = err_r;

`ifdef MC_INSTR_COUNT_EN
  logic        retire_s;
  logic [31:0] instr_cnt_r;

  assign retire_s = (state_next_s == S_FETCH) && (state_r != S_FETCH);

  // Retired instruction counter; ERROR never returns to FETCH so it cannot count there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_r <= 32'd0;
    end else if (retire_s) begin
      instr_cnt_r <= instr_cnt_r + 32'd1;
    end else begin
      instr_cnt_r <= instr_cnt_r;
    end
  end

  assign instr_retired = instr_cnt_r;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed scoreboard bench for mc_control_fsm (MAX_WAIT=15); counter checks under MC_INSTR_COUNT_EN.
module tb_mc_control_fsm;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       ir_write, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_Op, pc_source, err_code;
  logic [3:0] state;
`ifdef MC_INSTR_COUNT_EN
  logic [31:0] instr_retired;
`endif

  mc_control_fsm #(.MAX_WAIT(15), .STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_Op(alu_Op),
    .pc_source(pc_source), .state(state), .err_code(err_code)
`ifdef MC_INSTR_COUNT_EN
    , .instr_retired(instr_retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [1:0]  err;
    logic [15:0] strb;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Strobes expected from the state table: {pcw,pcc,iod,mr,mw,m2r,irw,rd,rw,sa,srcb,aop,psrc}
  function automatic logic [15:0] model_strb(input logic [3:0] st, input logic rdy);
    logic pcw, pcc, iod, mr, mw, m2r, irw, rd, rw, sa;
    logic [1:0] sb, aop, ps;
    {pcw, pcc, iod, mr, mw, m2r, irw, rd, rw, sa} = 10'b0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    case (st)
      4'd0:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  sb = 2'b11;
      4'd2:  begin sa = 1'b1; sb = 2'b10; end
      4'd3:  begin mr = 1'b1; iod = 1'b1; end
      4'd4:  begin rw = 1'b1; m2r = 1'b1; end
      4'd5:  begin mw = 1'b1; iod = 1'b1; end
      4'd6:  begin sa = 1'b1; aop = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin sa = 1'b1; aop = 2'b01; pcc = 1'b1; ps = 2'b01; end
      4'd9:  begin pcw = 1'b1; ps = 2'b10; end
      4'd10: begin sa = 1'b1; sb = 2'b10; end
      4'd11: rw = 1'b1;
      default: ;
    endcase
    return {pcw, pcc, iod, mr, mw, m2r, irw, rd, rw, sa, sb, aop, ps};
  endfunction

  function automatic logic [15:0] dut_strb();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write,
            reg_dst, reg_write, alu_src_a, alu_src_b, alu_Op, pc_source};
  endfunction

  task automatic check_now(input string tag);
    exp_t e;
    e = sb_q.pop_front();
    vectors++;
    assert (state === e.st) else begin
      miscompares++;
      $error("FAIL %s state got=%0d exp=%0d", tag, state, e.st);
    end
    vectors++;
    assert (dut_strb() === e.strb) else begin
      miscompares++;
      $error("FAIL %s strobes got=%h exp=%h", tag, dut_strb(), e.strb);
    end
    vectors++;
    assert (err_code === e.err) else begin
      miscompares++;
      $error("FAIL %s err_code got=%0d exp=%0d", tag, err_code, e.err);
    end
  endtask

  // Entered at a negedge: drive inputs, check current-state outputs, advance one cycle
  task automatic step(input logic [5:0] op, input logic rdy, input logic [3:0] st,
                      input logic [1:0] err, input string tag);
    exp_t e;
    opcode = op;
    mem_ready = rdy;
    e.st = st; e.err = err; e.strb = model_strb(st, rdy);
    sb_q.push_back(e);
    #1;
    check_now(tag);
    @(negedge clk);
  endtask

  // Asynchronous reset between edges: everything must read zero immediately
  task automatic async_reset(input string tag);
    exp_t e;
    #2;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    e.st = 4'd0; e.err = 2'b00; e.strb = 16'h0000;
    sb_q.push_back(e);
    #1;
    check_now(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef MC_INSTR_COUNT_EN
  task automatic check_count(input logic [31:0] exp, input string tag);
    vectors++;
    assert (instr_retired === exp) else begin
      miscompares++;
      $error("FAIL %s instr_retired got=%0d exp=%0d", tag, instr_retired, exp);
    end
  endtask
`endif

  initial begin
    exp_t e;
    #12;
    e.st = 4'd0; e.err = 2'b00; e.strb = 16'h0000;
    sb_q.push_back(e);
    check_now("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // lw, no waits: 0,1,2,3,4
    step(LW, 1'b1, 4'd0, 2'b00, "lw_fetch");
    step(LW, 1'b1, 4'd1, 2'b00, "lw_decode");
    step(LW, 1'b1, 4'd2, 2'b00, "lw_addr");
    step(LW, 1'b1, 4'd3, 2'b00, "lw_read");
    step(LW, 1'b1, 4'd4, 2'b00, "lw_wb");
    // sw with three wait cycles in MEM_WRITE
    step(SW, 1'b1, 4'd0, 2'b00, "sw_fetch");
    step(SW, 1'b1, 4'd1, 2'b00, "sw_decode");
    step(SW, 1'b1, 4'd2, 2'b00, "sw_addr");
    for (int i = 0; i < 3; i++) step(SW, 1'b0, 4'd5, 2'b00, "sw_wait");
    step(SW, 1'b1, 4'd5, 2'b00, "sw_done");
    // R-type, beq, j, addi
    step(RT, 1'b1, 4'd0, 2'b00, "r_fetch");
    step(RT, 1'b1, 4'd1, 2'b00, "r_decode");
    step(RT, 1'b1, 4'd6, 2'b00, "r_exec");
    step(RT, 1'b1, 4'd7, 2'b00, "r_complete");
    step(BEQ, 1'b1, 4'd0, 2'b00, "beq_fetch");
    step(BEQ, 1'b1, 4'd1, 2'b00, "beq_decode");
    step(BEQ, 1'b1, 4'd8, 2'b00, "beq_branch");
    step(JMP, 1'b1, 4'd0, 2'b00, "j_fetch");
    step(JMP, 1'b1, 4'd1, 2'b00, "j_decode");
    step(JMP, 1'b1, 4'd9, 2'b00, "j_jump");
    step(ADDI, 1'b1, 4'd0, 2'b00, "addi_fetch");
    step(ADDI, 1'b1, 4'd1, 2'b00, "addi_decode");
    step(ADDI, 1'b1, 4'd10, 2'b00, "addi_exec");
    step(ADDI, 1'b1, 4'd11, 2'b00, "addi_wb");
    // Illegal opcode: sticky ERROR
    step(BAD, 1'b1, 4'd0, 2'b00, "bad_fetch");
    step(BAD, 1'b1, 4'd1, 2'b00, "bad_decode");
    for (int i = 0; i < 20; i++) step(LW, i[0], 4'd15, 2'b01, "bad_error_hold");
    async_reset("reset_after_illegal");
    // FETCH timeout on the 15th wait cycle
    for (int i = 0; i < 15; i++) step(JMP, 1'b0, 4'd0, 2'b00, "fetch_wait");
    step(JMP, 1'b1, 4'd15, 2'b10, "fetch_timeout");
    step(JMP, 1'b1, 4'd15, 2'b10, "timeout_hold");
    async_reset("reset_after_timeout");
    // Ready on the 15th cycle wins
    for (int i = 0; i < 14; i++) step(JMP, 1'b0, 4'd0, 2'b00, "fetch_wait14");
    step(JMP, 1'b1, 4'd0, 2'b00, "fetch_ready15");
    step(JMP, 1'b1, 4'd1, 2'b00, "late_decode");
    step(JMP, 1'b1, 4'd9, 2'b00, "late_jump");
    // Reset mid-MEM_READ
    step(LW, 1'b1, 4'd0, 2'b00, "abort_fetch");
    step(LW, 1'b1, 4'd1, 2'b00, "abort_decode");
    step(LW, 1'b1, 4'd2, 2'b00, "abort_addr");
    opcode = LW;
    mem_ready = 1'b0;
    e.st = 4'd3; e.err = 2'b00; e.strb = model_strb(4'd3, 1'b0);
    sb_q.push_back(e);
    #1;
    check_now("abort_read");
    async_reset("reset_mid_read");
`ifdef MC_INSTR_COUNT_EN
    check_count(32'd0, "count_reset");
`endif
    // lw, sw, j retire three instructions
    step(LW, 1'b1, 4'd0, 2'b00, "cnt_lw0");
    step(LW, 1'b1, 4'd1, 2'b00, "cnt_lw1");
    step(LW, 1'b1, 4'd2, 2'b00, "cnt_lw2");
    step(LW, 1'b1, 4'd3, 2'b00, "cnt_lw3");
    step(LW, 1'b1, 4'd4, 2'b00, "cnt_lw4");
    step(SW, 1'b1, 4'd0, 2'b00, "cnt_sw0");
    step(SW, 1'b1, 4'd1, 2'b00, "cnt_sw1");
    step(SW, 1'b1, 4'd2, 2'b00, "cnt_sw2");
    step(SW, 1'b1, 4'd5, 2'b00, "cnt_sw5");
    step(JMP, 1'b1, 4'd0, 2'b00, "cnt_j0");
    step(JMP, 1'b1, 4'd1, 2'b00, "cnt_j1");
    step(JMP, 1'b1, 4'd9, 2'b00, "cnt_j9");
    step(JMP, 1'b0, 4'd0, 2'b00, "cnt_back_fetch");
`ifdef MC_INSTR_COUNT_EN
    check_count(32'd3, "count_after_three");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
